// File: rtl/periph_bridge_pkg.sv
// Shared definitions for the 0x2xxx_xxxx peripheral bridge: FSM state type, error
// completion data and the slot-index-to-one-hot helper.
package periph_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    localparam logic [31:0] ERR_DATA_UNMAPPED = 32'h0000_0000;
    localparam logic [31:0] ERR_DATA_TIMEOUT  = 32'hFFFF_FFFF;

    localparam int unsigned MAX_SLOTS = 32;

    function automatic logic [MAX_SLOTS-1:0] slot_to_onehot(input logic [4:0] idx);
        return MAX_SLOTS'(1) << idx;
    endfunction

endpackage

// File: rtl/periph_bridge_timer.sv
// WAIT-state watchdog for periph_bridge: cleared by load_i, counts while en_i, and flags
// expire_o during the LIMIT-th enabled cycle.
module periph_bridge_timer
    import periph_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset_i || load_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expire_o = en_i && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/periph_bridge.sv
// Registered CPU-to-peripheral bridge: decodes one request to a slot, strobes sel_o, waits
// for pready_i and returns data. Optional WAIT timeout under PERIPH_BRIDGE_TIMEOUT_EN.
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_BITS   = 2,
    parameter int unsigned SLOT_LSB    = 12,
    parameter logic [3:0]  BASE_NIBBLE = 4'h2,
    parameter int unsigned PADDR_W     = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic                      req_i,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [3:0]                wr_mask_i,
    input  logic [31:0]               data_i,
    output logic [31:0]               data_o,
    output logic                      ready_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic [NUM_SLOTS-1:0]      sel_o,
    output logic                      pwe_o,
    output logic [PADDR_W-1:0]        paddr_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pmask_o,
    input  logic [NUM_SLOTS*32-1:0]   prdata_i,
    input  logic [NUM_SLOTS-1:0]      pready_i
);

    state_e               r_state, w_state_d;
    logic [SLOT_BITS-1:0] r_slot;
    logic                 r_we;
    logic [PADDR_W-1:0]   r_paddr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_mask;
    logic [31:0]          r_rdata, w_rdata_d;
    logic                 r_err, w_err_d;

    logic                 w_in_region;
    logic [SLOT_BITS-1:0] w_slot;
    logic                 w_slot_ok;
    logic                 w_latch;
    logic                 w_pready;
    logic [31:0]          w_prdata;
    logic                 w_unused;

    assign w_in_region = (addr_i[31:28] == BASE_NIBBLE);
    assign w_slot      = addr_i[SLOT_LSB +: SLOT_BITS];
    assign w_slot_ok   = (32'(w_slot) < NUM_SLOTS);
    // Only the nibble, slot field and offset are decoded; the rest is don't-care.
    assign w_unused    = ^{addr_i, 32'(TIMEOUT_CYC)};

    // Only the latched slot's handshake and data are observed.
    always_comb begin
        w_pready = 1'b0;
        w_prdata = '0;
        for (int k = 0; k < int'(NUM_SLOTS); k++) begin
            if (r_slot == SLOT_BITS'(k)) begin
                w_pready = pready_i[k];
                w_prdata = prdata_i[k*32 +: 32];
            end
        end
    end

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    logic w_expire;
    logic w_tmr_load;
    logic w_tmr_en;

    assign w_tmr_load = w_latch && w_slot_ok;
    assign w_tmr_en   = (r_state == StWait);

    periph_bridge_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset_i (reset_i),
        .load_i  (w_tmr_load),
        .en_i    (w_tmr_en),
        .expire_o(w_expire)
    );
`endif

    always_comb begin
        w_state_d = r_state;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_i && w_in_region) begin
                    w_latch = 1'b1;
                    if (w_slot_ok) begin
                        w_state_d = StAccess;
                    end else begin
                        w_state_d = StResp;
                        w_rdata_d = ERR_DATA_UNMAPPED;
                        w_err_d   = 1'b1;
                    end
                end
            end
            StAccess, StWait: begin
                if (w_pready) begin
                    w_state_d = StResp;
                    w_rdata_d = r_we ? 32'h0 : w_prdata;
                    w_err_d   = 1'b0;
                end else if (r_state == StAccess) begin
                    w_state_d = StWait;
                end
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_d = StResp;
                    w_rdata_d = ERR_DATA_TIMEOUT;
                    w_err_d   = 1'b1;
                end
`endif
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_slot  <= '0;
            r_we    <= 1'b0;
            r_paddr <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
            if (w_latch) begin
                r_slot  <= w_slot;
                r_we    <= we_i;
                r_paddr <= addr_i[PADDR_W-1:0];
                r_wdata <= data_i;
                r_mask  <= wr_mask_i;
            end
        end
    end

    assign ready_o  = (r_state == StResp);
    assign data_o   = ready_o ? r_rdata : 32'h0;
    assign err_o    = ready_o && r_err;
    assign busy_o   = (r_state != StIdle);
    assign sel_o    = (r_state == StAccess) ? NUM_SLOTS'(slot_to_onehot(5'(r_slot))) : '0;
    assign pwe_o    = r_we;
    assign paddr_o  = r_paddr;
    assign pwdata_o = r_wdata;
    assign pmask_o  = r_mask;

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge (3 slots, so slot 3 is unmapped); responses are
// checked against a queue of expected completions filled as each request is driven.
module tb_periph_bridge;

    localparam int unsigned NS = 3;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              req_i;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [3:0]        wr_mask_i;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic              ready_o;
    logic              err_o;
    logic              busy_o;
    logic [NS-1:0]     sel_o;
    logic              pwe_o;
    logic [11:0]       paddr_o;
    logic [31:0]       pwdata_o;
    logic [3:0]        pmask_o;
    logic [NS*32-1:0]  prdata_i;
    logic [NS-1:0]     pready_i;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;

    int            t_lat;
    int            t_sel_cnt;
    int            t_busy_low;
    logic [NS-1:0] t_sel_or;
    logic          t_pwe;
    logic [11:0]   t_paddr;
    logic [31:0]   t_pwdata;

    always #5 clk = ~clk;

    periph_bridge #(
        .NUM_SLOTS  (NS),
        .SLOT_BITS  (2),
        .SLOT_LSB   (12),
        .BASE_NIBBLE(4'h2),
        .PADDR_W    (12),
        .TIMEOUT_CYC(8)
    ) u_dut (
        .clk      (clk),
        .reset_i  (reset_i),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wr_mask_i(wr_mask_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .ready_o  (ready_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .sel_o    (sel_o),
        .pwe_o    (pwe_o),
        .paddr_o  (paddr_o),
        .pwdata_o (pwdata_o),
        .pmask_o  (pmask_o),
        .prdata_i (prdata_i),
        .pready_i (pready_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (ready_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ready", 32'(ready_o), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rsp_err", 32'(err_o), 32'(mon_e.err));
                    check_eq("rsp_data", data_o, mon_e.data);
                end
            end else begin
                check_eq("quiet_rsp", data_o | 32'(err_o), 32'd0);
            end
        end
    end

    // Drives one request; the selected slot raises pready dly cycles after sel (dly<0: never).
    task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input int slot, input int dly, input int budget, input bit push,
                              input logic exp_err, input logic [31:0] exp_data);
        int sel_cyc;
        sel_cyc    = -1;
        t_lat      = -1;
        t_sel_cnt  = 0;
        t_sel_or   = '0;
        t_busy_low = 0;
        @(posedge clk);
        #1;
        req_i     = 1'b1;
        addr_i    = addr;
        we_i      = we;
        data_i    = wdata;
        wr_mask_i = 4'hF;
        if (push) exp_q.push_back(rsp_t'{exp_err, exp_data});
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i > 0 && !busy_o) t_busy_low++;
            if (sel_o != '0) begin
                t_sel_cnt++;
                t_sel_or |= sel_o;
                sel_cyc  = i;
                t_pwe    = pwe_o;
                t_paddr  = paddr_o;
                t_pwdata = pwdata_o;
            end
            if (ready_o) begin
                t_lat = i;
                break;
            end
            if (slot < int'(NS) && dly >= 0 && sel_cyc >= 0 && i >= sel_cyc + dly)
                pready_i[slot] = 1'b1;
        end
        req_i = 1'b0;
        if (slot < int'(NS)) pready_i[slot] = 1'b0;
    endtask

    initial begin
        reset_i   = 1'b1;
        req_i     = 1'b0;
        addr_i    = '0;
        we_i      = 1'b0;
        wr_mask_i = '0;
        data_i    = '0;
        prdata_i  = '0;
        pready_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_ready", 32'(ready_o), 32'd0);
        check_eq("rst_sel", 32'(sel_o), 32'd0);
        check_eq("rst_pwe", 32'(pwe_o), 32'd0);
        check_eq("rst_paddr", 32'(paddr_o), 32'd0);
        check_eq("rst_data", data_o | 32'(err_o), 32'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;

        // 1: write to slot 1 with pready held high
        prdata_i[32 +: 32] = 32'hDEAD_BEEF;
        pready_i[1] = 1'b1;
        run_access(32'h2000_1000, 1'b1, 32'h0000_00A5, 1, 0, 10, 1'b1, 1'b0, 32'h0);
        check_eq("t1_latency", 32'(t_lat), 32'd2);
        check_eq("t1_sel_cnt", 32'(t_sel_cnt), 32'd1);
        check_eq("t1_sel", 32'(t_sel_or), 32'b010);
        check_eq("t1_pwe", 32'(t_pwe), 32'd1);
        check_eq("t1_pwdata", t_pwdata, 32'h0000_00A5);

        // 2: read from slot 2 after a 3-cycle stall; slot 0 noise must be ignored
        prdata_i[0 +: 32]  = 32'hBAD0_BAD0;
        prdata_i[64 +: 32] = 32'h0000_1234;
        pready_i[0] = 1'b1;
        run_access(32'h2000_2004, 1'b0, 32'h0, 2, 3, 20, 1'b1, 1'b0, 32'h0000_1234);
        pready_i[0] = 1'b0;
        check_eq("t2_latency", 32'(t_lat), 32'd5);
        check_eq("t2_busy_low", 32'(t_busy_low), 32'd0);
        check_eq("t2_sel", 32'(t_sel_or), 32'b100);
        check_eq("t2_paddr", 32'(t_paddr), 32'h004);
        check_eq("t2_pwe", 32'(t_pwe), 32'd0);

        // 3: unmapped slot
        run_access(32'h2000_3000, 1'b0, 32'h0, 3, -1, 10, 1'b1, 1'b1, 32'h0);
        check_eq("t3_latency", 32'(t_lat), 32'd1);
        check_eq("t3_sel_cnt", 32'(t_sel_cnt), 32'd0);

        // 4: slot never ready
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
        run_access(32'h2000_0008, 1'b0, 32'h0, 0, -1, 30, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check_eq("t4_latency", 32'(t_lat), 32'd10);
        check_eq("t4_sel_cnt", 32'(t_sel_cnt), 32'd1);
        run_access(32'h2000_0008, 1'b0, 32'h0, 0, -1, 4, 1'b0, 1'b0, 32'h0);
        check_eq("t4_stalled", 32'(t_lat), 32'hFFFF_FFFF);
`else
        run_access(32'h2000_0008, 1'b0, 32'h0, 0, -1, 1000, 1'b0, 1'b0, 32'h0);
        check_eq("t4_no_rsp", 32'(t_lat), 32'hFFFF_FFFF);
        check_eq("t4_still_busy", 32'(busy_o), 32'd1);
`endif

        // 5: reset during WAIT, late pready, then a fresh request
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t5_busy", 32'(busy_o), 32'd0);
        check_eq("t5_ready", 32'(ready_o), 32'd0);
        check_eq("t5_sel", 32'(sel_o), 32'd0);
        check_eq("t5_rsp", data_o | 32'(err_o), 32'd0);
        check_eq("t5_pouts", 32'(pwe_o) | 32'(paddr_o) | pwdata_o | 32'(pmask_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        prdata_i[0 +: 32] = 32'h5555_5555;
        pready_i[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t5_late_busy", 32'(busy_o), 32'd0);
            check_eq("t5_late_ready", 32'(ready_o), 32'd0);
        end
        pready_i[0] = 1'b0;
        prdata_i[64 +: 32] = 32'h0000_CAFE;
        run_access(32'h2000_2010, 1'b0, 32'h0, 2, 1, 10, 1'b1, 1'b0, 32'h0000_CAFE);
        check_eq("t5_fresh_latency", 32'(t_lat), 32'd3);

        // 6: out-of-region request is ignored
        run_access(32'h1000_0000, 1'b1, 32'h77, 0, -1, 5, 1'b0, 1'b0, 32'h0);
        check_eq("t6_no_rsp", 32'(t_lat), 32'hFFFF_FFFF);
        check_eq("t6_sel_cnt", 32'(t_sel_cnt), 32'd0);
        check_eq("t6_idle", 32'(t_busy_low), 32'd4);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
